// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// bit-counter sizing helper.
package serial_subtractor_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bus of the serial subtractor.
// ovf_out exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             start_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             borrow_in;
    logic             busy_out;
    logic             done_out;
    logic [WIDTH-1:0] diff_out;
    logic             borrow_out;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_out;
`endif

    modport master (
        output start_in, a_in, b_in, borrow_in,
        input  busy_out, done_out, diff_out, borrow_out
`ifdef SERIAL_SUB_OVF_EN
        , input ovf_out
`endif
    );

    modport slave (
        input  start_in, a_in, b_in, borrow_in,
        output busy_out, done_out, diff_out, borrow_out
`ifdef SERIAL_SUB_OVF_EN
        , output ovf_out
`endif
    );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, bout = borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, one bit per clock, LSB first.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf_out.
//
// state | meaning
// IDLE  | waiting for start_in; results held
// RUN   | processing one operand bit per clock
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                clk_in,
    input  logic                rst_in,
    serial_subtractor_if.slave  bus
);

    localparam int              CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             done_q;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             load, last;
    logic             d_bit, br_nxt;

    full_subtractor u_fsub (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (br),
        .d    (d_bit),
        .bout (br_nxt)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start_in) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    last      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef SERIAL_SUB_OVF_EN
    logic a_sgn, b_sgn, ovf_q;

    // Operand signs are captured at accept since the shift regs lose them.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            a_sgn <= 1'b0;
            b_sgn <= 1'b0;
            ovf_q <= 1'b0;
        end else if (load) begin
            a_sgn <= bus.a_in[WIDTH-1];
            b_sgn <= bus.b_in[WIDTH-1];
        end else if (last) begin
            ovf_q <= (a_sgn != b_sgn) && (d_bit != a_sgn);
        end
    end

    assign bus.ovf_out = ovf_q;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            br       <= 1'b0;
            cnt      <= '0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            done_q <= last;
            if (load) begin
                a_sr <= bus.a_in;
                b_sr <= bus.b_in;
                br   <= bus.borrow_in;
                cnt  <= '0;
            end else if (state == RUN) begin
                a_sr   <= a_sr >> 1;
                b_sr   <= b_sr >> 1;
                br     <= br_nxt;
                cnt    <= cnt + 1'b1;
                res_sr <= {d_bit, res_sr[WIDTH-1:1]};
                if (last) begin
                    diff_q   <= {d_bit, res_sr[WIDTH-1:1]};
                    borrow_q <= br_nxt;
                end
            end
        end
    end

    assign bus.busy_out   = (state == RUN);
    assign bus.done_out   = done_q;
    assign bus.diff_out   = diff_q;
    assign bus.borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=4).
// Define SERIAL_SUB_OVF_EN to also check ovf_out.
module tb_serial_subtractor;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(W)) sif ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (sif.slave)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Call just after a negedge with the DUT idle; returns at the first
    // negedge after the accept edge, with operands scrambled.
    task automatic launch(input logic [3:0] a, input logic [3:0] b, input logic bin);
        sif.start_in  = 1'b1;
        sif.a_in      = a;
        sif.b_in      = b;
        sif.borrow_in = bin;
        @(posedge clk);
        @(negedge clk);
        sif.start_in  = 1'b0;
        sif.a_in      = ~a;
        sif.b_in      = ~b;
        sif.borrow_in = ~bin;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!sif.done_out && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic op(input logic [3:0] a, input logic [3:0] b, input logic bin, output int lat);
        @(negedge clk);
        launch(a, b, bin);
        wait_done(lat);
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (sif.done_out) n++;
        end
    endtask

    int         lat;
    int         n;
    logic [3:0] ed;
    logic       eb;

    initial begin
        sif.start_in  = 1'b0;
        sif.a_in      = '0;
        sif.b_in      = '0;
        sif.borrow_in = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy",   sif.busy_out,   0);
        check("rst_done",   sif.done_out,   0);
        check("rst_diff",   sif.diff_out,   0);
        check("rst_borrow", sif.borrow_out, 0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst_ovf",    sif.ovf_out,    0);
`endif
        rst = 1'b0;

        // 9 - 3 = 6
        @(negedge clk);
        launch(4'd9, 4'd3, 1'b0);
        check("busy_run", sif.busy_out, 1);
        wait_done(lat);
        check("lat_9_3",    lat,            4);
        check("diff_9_3",   sif.diff_out,   4'd6);
        check("brw_9_3",    sif.borrow_out, 0);
        check("busy_done",  sif.busy_out,   0);
        @(negedge clk);
        check("done_pulse", sif.done_out,   0);
        check("diff_hold",  sif.diff_out,   4'd6);

        // 3 - 9 wraps
        op(4'd3, 4'd9, 1'b0, lat);
        check("diff_3_9", sif.diff_out,   4'hA);
        check("brw_3_9",  sif.borrow_out, 1);

        // 0 - 0 - 1
        op(4'd0, 4'd0, 1'b1, lat);
        check("diff_0_0_1", sif.diff_out,   4'hF);
        check("brw_0_0_1",  sif.borrow_out, 1);

        // start during busy is ignored
        @(negedge clk);
        launch(4'd7, 4'd2, 1'b0);
        @(negedge clk);
        sif.start_in = 1'b1;
        sif.a_in     = 4'd1;
        sif.b_in     = 4'd1;
        @(negedge clk);
        sif.start_in = 1'b0;
        wait_done(lat);
        check("ign_lat",  lat,            2);
        check("ign_diff", sif.diff_out,   4'd5);
        check("ign_brw",  sif.borrow_out, 0);
        count_dones(8, n);
        check("ign_single_done", n, 0);

        // reset in second RUN cycle aborts
        @(negedge clk);
        launch(4'd7, 4'd2, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", sif.busy_out,   0);
        check("abort_done", sif.done_out,   0);
        check("abort_diff", sif.diff_out,   0);
        check("abort_brw",  sif.borrow_out, 0);
        count_dones(8, n);
        check("abort_no_done", n, 0);
        op(4'd7, 4'd2, 1'b0, lat);
        check("post_abort_lat",  lat,          4);
        check("post_abort_diff", sif.diff_out, 4'd5);

        // back-to-back: second start in the done cycle
        op(4'd15, 4'd1, 1'b0, lat);
        check("b2b_diff1", sif.diff_out,   4'd14);
        check("b2b_brw1",  sif.borrow_out, 0);
        launch(4'd2, 4'd5, 1'b0);
        wait_done(lat);
        check("b2b_lat2",  lat,            4);
        check("b2b_diff2", sif.diff_out,   4'd13);
        check("b2b_brw2",  sif.borrow_out, 1);

`ifdef SERIAL_SUB_OVF_EN
        op(4'd8, 4'd1, 1'b0, lat);
        check("ovf_diff_8_1", sif.diff_out, 4'd7);
        check("ovf_8_1",      sif.ovf_out,  1);
        op(4'd5, 4'd3, 1'b0, lat);
        check("ovf_diff_5_3", sif.diff_out, 4'd2);
        check("ovf_5_3",      sif.ovf_out,  0);
`endif

        // full sweep against a reference model
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    ed = 4'((a - b - c) & 15);
                    eb = (a < b + c);
                    op(4'(a), 4'(b), c[0], lat);
                    check("sweep_lat",  lat,            4);
                    check("sweep_diff", sif.diff_out,   ed);
                    check("sweep_brw",  sif.borrow_out, eb);
`ifdef SERIAL_SUB_OVF_EN
                    check("sweep_ovf", sif.ovf_out,
                          ((a >= 8) != (b >= 8)) && (ed[3] != (a >= 8)));
`endif
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
